// File: rtl/urv_console_uart.sv
// Console/test-status peripheral for the uRV data bus: a TX byte FIFO drained by an
// 8N1 UART transmitter, a sticky test-done register and a pollable status register.
module urv_console_uart #(
  parameter logic [31:0] g_base_addr  = 32'h0010_0000,
  parameter int          g_clk_div    = 16,
  parameter int          g_fifo_depth = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_store_i,
  input  logic        dm_load_i,
  output logic [31:0] dm_data_l_o,
  output logic        dm_store_done_o,
  output logic        dm_load_done_o,
  output logic        uart_txd_o,
  output logic        test_done_o,
  output logic [7:0]  test_code_o
);

  localparam int             PTR_W     = $clog2(g_fifo_depth);
  localparam logic [15:0]    BIT_TICKS = 16'(g_clk_div - 1);
  localparam logic [PTR_W:0] PTR_ONE   = (PTR_W + 1)'(1);
  localparam logic [29:0]    TX_WORD   = g_base_addr[31:2];
  localparam logic [29:0]    DONE_WORD = g_base_addr[31:2] + 30'd1;
  localparam logic [29:0]    STAT_WORD = g_base_addr[31:2] + 30'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_t;

  tx_state_t      state;
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic [PTR_W:0] level;
  logic [7:0]     fifo_mem [g_fifo_depth];
  logic [7:0]     shift_reg;
  logic [2:0]     bit_cnt;
  logic [15:0]    bit_timer;
  logic           txd;
  logic           sel_tx;
  logic           sel_done;
  logic           sel_stat;
  logic           fifo_full;
  logic           fifo_empty;
  logic           push;
  logic           pop;
  logic           busy;
  logic [7:0]     level_sat;
  logic [31:0]    stat_word;
  logic           unused_bits;

  assign unused_bits = ^{dm_addr_i[1:0], dm_data_s_i[31:8], dm_data_select_i[3:1]};

  assign sel_tx   = (dm_addr_i[31:2] == TX_WORD);
  assign sel_done = (dm_addr_i[31:2] == DONE_WORD);
  assign sel_stat = (dm_addr_i[31:2] == STAT_WORD);

  // Extra pointer MSB distinguishes a wrapped (full) FIFO from an empty one.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign level      = wr_ptr - rd_ptr;
  assign level_sat  = (32'(level) > 32'd255) ? 8'hFF : 8'(level);

  assign busy      = (state != S_IDLE);
  assign pop       = (state == S_IDLE) && !fifo_empty;
  assign push      = dm_store_i && sel_tx && dm_data_select_i[0] && !fifo_full;
  assign stat_word = {16'h0000, level_sat, 5'b00000, busy, fifo_full, fifo_empty};

  // A TX store against a full FIFO stalls the CPU until a pop has freed a slot.
  assign dm_store_done_o = dm_store_i && !(sel_tx && fifo_full);
  assign uart_txd_o      = txd;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push)
      fifo_mem[wr_ptr[PTR_W-1:0]] <= dm_data_s_i[7:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      shift_reg <= 8'h00;
      bit_cnt   <= 3'd0;
      bit_timer <= 16'd0;
      txd       <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          txd <= 1'b1;
          if (!fifo_empty) begin
            shift_reg <= fifo_mem[rd_ptr[PTR_W-1:0]];
            bit_timer <= BIT_TICKS;
            txd       <= 1'b0;
            state     <= S_START;
          end
        end
        S_START: begin
          if (bit_timer == 16'd0) begin
            bit_timer <= BIT_TICKS;
            bit_cnt   <= 3'd0;
            txd       <= shift_reg[0];
            state     <= S_DATA;
          end else begin
            bit_timer <= bit_timer - 16'd1;
          end
        end
        S_DATA: begin
          if (bit_timer == 16'd0) begin
            bit_timer <= BIT_TICKS;
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              txd   <= 1'b1;
              state <= S_STOP;
            end else begin
              txd       <= shift_reg[1];
              shift_reg <= {1'b0, shift_reg[7:1]};
            end
          end else begin
            bit_timer <= bit_timer - 16'd1;
          end
        end
        S_STOP: begin
          txd <= 1'b1;
          if (bit_timer == 16'd0)
            state <= S_IDLE;
          else
            bit_timer <= bit_timer - 16'd1;
        end
        default: begin
          txd   <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dm_load_done_o <= 1'b0;
      dm_data_l_o    <= 32'h0;
    end else begin
      dm_load_done_o <= dm_load_i;
      dm_data_l_o    <= (dm_load_i && sel_stat) ? stat_word : 32'h0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      test_done_o <= 1'b0;
      test_code_o <= 8'h00;
    end else if (dm_store_i && sel_done) begin
      test_done_o <= 1'b1;
      test_code_o <= dm_data_s_i[7:0];
    end
  end

endmodule

// File: tb/tb_urv_console_uart.sv
// Bench for urv_console_uart: a queue/frame-position model checked against the DUT every
// cycle, plus literal expectations for reset, framing, stall length and status words.
module tb_urv_console_uart;

  localparam logic [31:0] BASE  = 32'h0010_0000;
  localparam int          DIV   = 16;
  localparam int          DEPTH = 16;

  logic        clk;
  logic        rst;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_sel;
  logic        dm_store;
  logic        dm_load;
  logic [31:0] dm_rdata;
  logic        store_done;
  logic        load_done;
  logic        txd;
  logic        test_done;
  logic [7:0]  test_code;

  urv_console_uart #(
    .g_base_addr (BASE),
    .g_clk_div   (DIV),
    .g_fifo_depth(DEPTH)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .dm_addr_i       (dm_addr),
    .dm_data_s_i     (dm_wdata),
    .dm_data_select_i(dm_sel),
    .dm_store_i      (dm_store),
    .dm_load_i       (dm_load),
    .dm_data_l_o     (dm_rdata),
    .dm_store_done_o (store_done),
    .dm_load_done_o  (load_done),
    .uart_txd_o      (txd),
    .test_done_o     (test_done),
    .test_code_o     (test_code)
  );

  int checks;
  int failures;
  int cyc;

  // Model: bytes waiting in the FIFO, and position (in clocks) inside the frame on the wire.
  logic [7:0]  mq[$];
  int          frame_pos;
  logic [7:0]  cur_byte;
  logic        m_done;
  logic [7:0]  m_code;
  logic        m_ld_done;
  logic [31:0] m_ld_data;
  logic [31:0] m_stat;
  logic        m_accept;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h cycle=%0d", name, actual, expected, cyc);
    end
  endtask

  function automatic logic is_word(input logic [31:0] a, input int idx);
    return (a & 32'hFFFF_FFFC) == (BASE + 32'(4 * idx));
  endfunction

  function automatic logic exp_txd();
    int slot;
    if (frame_pos < 0) return 1'b1;
    slot = frame_pos / DIV;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return cur_byte[slot-1];
  endfunction

  function automatic logic [31:0] model_stat();
    int n;
    n = mq.size();
    return {16'h0000, 8'(n > 255 ? 255 : n), 5'b00000, frame_pos >= 0, n == DEPTH, n == 0};
  endfunction

  function automatic logic exp_store_done();
    return dm_store && !(is_word(dm_addr, 0) && mq.size() == DEPTH);
  endfunction

  initial begin
    frame_pos = -1;
    cur_byte  = 8'h00;
    m_done    = 1'b0;
    m_code    = 8'h00;
    m_ld_done = 1'b0;
    m_ld_data = 32'h0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        frame_pos = -1;
        cur_byte  = 8'h00;
        m_done    = 1'b0;
        m_code    = 8'h00;
        m_ld_done = 1'b0;
        m_ld_data = 32'h0;
      end else begin
        m_stat    = model_stat();
        m_accept  = exp_store_done();
        m_ld_done = dm_load;
        m_ld_data = (dm_load && is_word(dm_addr, 2)) ? m_stat : 32'h0;
        if (dm_store && is_word(dm_addr, 1)) begin
          m_done = 1'b1;
          m_code = dm_wdata[7:0];
        end
        if (frame_pos >= 0) begin
          frame_pos++;
          if (frame_pos == 10 * DIV) frame_pos = -1;
        end else if (mq.size() != 0) begin
          cur_byte  = mq.pop_front();
          frame_pos = 0;
        end
        if (m_accept && is_word(dm_addr, 0) && dm_sel[0]) mq.push_back(dm_wdata[7:0]);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      checkOutput("cmp_txd", 32'(txd), 32'(exp_txd()));
      checkOutput("cmp_store_done", 32'(store_done), 32'(exp_store_done()));
      checkOutput("cmp_load_done", 32'(load_done), 32'(m_ld_done));
      checkOutput("cmp_load_data", dm_rdata, m_ld_data);
      checkOutput("cmp_test_done", 32'(test_done), 32'(m_done));
      checkOutput("cmp_test_code", 32'(test_code), 32'(m_code));
    end
  end

  task automatic applyStimulus(input logic is_load, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] sel, output int waited, output int acc_cyc);
    waited   = 0;
    dm_addr  = addr;
    dm_wdata = data;
    dm_sel   = sel;
    if (is_load) begin
      dm_load = 1'b1;
      @(negedge clk);
    end else begin
      dm_store = 1'b1;
      @(negedge clk);
      while (!store_done && waited < 1000) begin
        waited++;
        @(negedge clk);
      end
      if (!store_done) checkOutput("store_accept_timeout", 32'(store_done), 32'd1);
    end
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    dm_store = 1'b0;
    dm_load  = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [31:0] addr, input logic [31:0] expected);
    int w;
    int a;
    applyStimulus(1'b1, addr, 32'h0, 4'b1111, w, a);
    @(negedge clk);
    checkOutput({name, "_done"}, 32'(load_done), 32'd1);
    checkOutput(name, dm_rdata, expected);
    @(posedge clk);
    #1;
  endtask

  task automatic waitCycle(input int target);
    do @(negedge clk); while (cyc < target);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((mq.size() != 0 || frame_pos >= 0) && n < 6000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 6000) checkOutput("drain_timeout", 32'(txd), 32'(~txd));
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int waited;
    int acc;
    int total_wait;
    logic [9:0] pat;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    rst      = 1'b1;
    dm_addr  = 32'h0;
    dm_wdata = 32'h0;
    dm_sel   = 4'h0;
    dm_store = 1'b0;
    dm_load  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_txd", 32'(txd), 32'd1);
    checkOutput("reset_test_done", 32'(test_done), 32'd0);
    checkOutput("reset_test_code", 32'(test_code), 32'd0);
    checkOutput("reset_load_done", 32'(load_done), 32'd0);
    checkOutput("reset_load_data", dm_rdata, 32'd0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    readCheck("stat_after_reset", BASE + 32'd8, 32'h0000_0001);

    $display("[TB] single byte 0x55");
    applyStimulus(1'b0, BASE, 32'h0000_0055, 4'b0001, waited, acc);
    checkOutput("tx55_wait", 32'(waited), 32'd0);
    pat = 10'b1010101010;
    waitCycle(acc + 1);
    checkOutput("tx55_before_start", 32'(txd), 32'd1);
    for (int k = 0; k < 10; k++) begin
      waitCycle(acc + 2 + DIV * k);
      checkOutput("tx55_bit_first_clock", 32'(txd), 32'(pat[k]));
      waitCycle(acc + 2 + DIV * k + DIV - 1);
      checkOutput("tx55_bit_last_clock", 32'(txd), 32'(pat[k]));
    end
    waitCycle(acc + 2 + 10 * DIV);
    checkOutput("tx55_after_stop", 32'(txd), 32'd1);
    @(posedge clk);
    #1;
    waitDrain();

    $display("[TB] test done register");
    applyStimulus(1'b0, BASE + 32'd4, 32'h0000_00A5, 4'b1111, waited, acc);
    @(negedge clk);
    checkOutput("done_flag", 32'(test_done), 32'd1);
    checkOutput("done_code_a5", 32'(test_code), 32'h0000_00A5);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, BASE + 32'd4, 32'h0000_0000, 4'b1111, waited, acc);
    @(negedge clk);
    checkOutput("done_flag_sticky", 32'(test_done), 32'd1);
    checkOutput("done_code_00", 32'(test_code), 32'h0000_0000);
    @(posedge clk);
    #1;

    $display("[TB] byte lanes and decode");
    applyStimulus(1'b0, BASE, 32'h0000_0041, 4'b1110, waited, acc);
    readCheck("stat_after_lane0_clear", BASE + 32'd8, 32'h0000_0001);
    applyStimulus(1'b0, BASE + 32'd12, 32'h0000_0099, 4'b1111, waited, acc);
    checkOutput("undecoded_store_wait", 32'(waited), 32'd0);
    readCheck("undecoded_load", BASE + 32'd12, 32'h0);
    readCheck("done_reg_load", BASE + 32'd4, 32'h0);
    readCheck("tx_reg_load", BASE, 32'h0);

    $display("[TB] status during traffic");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, BASE, 32'h31 + 32'(i), 4'b0001, waited, acc);
    readCheck("stat_in_flight", BASE + 32'd8, 32'h0000_0204);
    waitDrain();

    $display("[TB] fifo full stall");
    total_wait = 0;
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1'b0, BASE, 32'h60 + 32'(i), 4'b0001, waited, acc);
      total_wait += waited;
    end
    checkOutput("full_stall_cycles", 32'(total_wait), 32'd146);
    waitDrain();

    $display("[TB] reset mid-frame");
    applyStimulus(1'b0, BASE + 32'd4, 32'h0000_0007, 4'b1111, waited, acc);
    applyStimulus(1'b0, BASE, 32'h0000_000F, 4'b0001, waited, acc);
    applyStimulus(1'b0, BASE, 32'h0000_00AA, 4'b0001, waited, acc);
    @(posedge clk);
    #2;
    checkOutput("pre_reset_txd", 32'(txd), 32'd0);
    checkOutput("pre_reset_done", 32'(test_done), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("async_reset_txd", 32'(txd), 32'd1);
    checkOutput("async_reset_done", 32'(test_done), 32'd0);
    checkOutput("async_reset_code", 32'(test_code), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    repeat (40) @(posedge clk);
    #1;
    readCheck("stat_after_mid_reset", BASE + 32'd8, 32'h0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    checkOutput("watchdog_txd_idle", 32'(txd), 32'(~txd));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
